sd_record_fetch: RTL and testbench

Parametrised SD-card record fetcher in the `SD_clk` domain, placed between game/control logic and `SD_read`. On a start pulse it requests one sector from a window of `NUM_SEC` sectors starting at `BASE_SEC`. It captures the first `REC_BYTES` bytes of that sector and presents them as one little-endian word. Unlike the fixed 4-byte, button-gated, free-running loader, it has an explicit start/done handshake, a selectable sector index, optional auto-increment with wrap, and a timeout error.

---
 rtl/sd_record_fetch.sv | 221 ++++++++++++++++++++++
 tb/tb_sd_record_fetch.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_record_fetch.sv
`default_nettype none
// ============================================================================
// Module   : sd_record_fetch
// Purpose  : Fetches one sector from a window of NUM_SEC sectors starting at
//            BASE_SEC through SD_read, captures the first REC_BYTES bytes and
//            publishes them as one little-endian word. Explicit start/done
//            handshake, selectable or auto-incrementing sector index with
//            wrap, and a request-to-completion timeout that raises err.
// Ports    :
//   SD_clk      in   SD SPI clock, all logic on its rising edge
//   rst_n       in   asynchronous active-low reset
//   start       in   one-cycle fetch request (ignored while busy)
//   auto_inc    in   1: use internal next index, 0: use sec_idx
//   sec_idx     in   sector offset within the window
//   busy        out  fetch in progress
//   rec_valid   out  one-cycle pulse when rec_data updates
//   rec_data    out  captured record, byte 0 in [7:0]
//   err         out  sticky error flag, cleared by the next good start
//   init_i      in   SD card initialised
//   read_req    out  level read request to SD_read
//   sec         out  sector address to SD_read
//   sd_data_i   in   byte from SD_read
//   sd_valid_i  in   byte strobe from SD_read
//   sd_done_i   in   SD_read sector finished
// Revision : 1.0 - initial release
// ============================================================================
module sd_record_fetch #(
   parameter int BASE_SEC  = 16640,
   parameter int NUM_SEC   = 33,
   parameter int REC_BYTES = 4,
   parameter int TIMEOUT   = 1048576
) (
   input  logic                   SD_clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic                   auto_inc,
   input  logic [31:0]            sec_idx,
   output logic                   busy,
   output logic                   rec_valid,
   output logic [8*REC_BYTES-1:0] rec_data,
   output logic                   err,
   input  logic                   init_i,
   output logic                   read_req,
   output logic [31:0]            sec,
   input  logic [7:0]             sd_data_i,
   input  logic                   sd_valid_i,
   input  logic                   sd_done_i
);

   localparam int c_rec_w = 8 * REC_BYTES;
   localparam int c_cnt_w = (REC_BYTES > 1) ? $clog2(REC_BYTES) : 1;
   localparam int c_tmo_w = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(REC_BYTES - 1);
   localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
   localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT - 1);
   localparam logic [c_tmo_w-1:0] c_tmo_one  = c_tmo_w'(1);
   localparam logic [31:0]        c_num_sec  = 32'(NUM_SEC);
   localparam logic [31:0]        c_base_sec = 32'(BASE_SEC);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_WAIT_INIT = 3'd1,
      ST_REQ       = 3'd2,
      ST_DRAIN     = 3'd3,
      ST_DONE      = 3'd4,
      ST_ERR       = 3'd5
   } state_t;

   state_t               state_q,     state_d;
   logic [31:0]          sec_q,       sec_d;
   logic [31:0]          idx_q,       idx_d;
   logic [31:0]          next_idx_q,  next_idx_d;
   logic [c_cnt_w-1:0]   cnt_q,       cnt_d;
   logic [c_tmo_w-1:0]   tmo_q,       tmo_d;
   logic [c_rec_w-1:0]   shadow_q,    shadow_d;
   logic [c_rec_w-1:0]   rec_data_q,  rec_data_d;
   logic                 rec_valid_q, rec_valid_d;
   logic                 err_q,       err_d;
   logic                 read_req_q,  read_req_d;
   logic                 busy_q,      busy_d;

   // Index requested by a start in IDLE.
   logic [31:0] w_idx;
   // Abort condition shared by REQ and DRAIN: card lost or timeout reached.
   logic        w_abort;

   assign w_idx   = auto_inc ? next_idx_q : sec_idx;
   assign w_abort = !init_i || (tmo_q == c_tmo_last);

   // ------------------------------------------------------------------------
   // Next-state and datapath logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      sec_d       = sec_q;
      idx_d       = idx_q;
      next_idx_d  = next_idx_q;
      cnt_d       = cnt_q;
      tmo_d       = '0;
      shadow_d    = shadow_q;
      rec_data_d  = rec_data_q;
      rec_valid_d = 1'b0;
      err_d       = err_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (w_idx >= c_num_sec) begin
                  state_d = ST_ERR;
                  err_d   = 1'b1;
               end else begin
                  sec_d   = c_base_sec + w_idx;
                  idx_d   = w_idx;
                  err_d   = 1'b0;
                  cnt_d   = '0;
                  state_d = init_i ? ST_REQ : ST_WAIT_INIT;
               end
            end
         end

         ST_WAIT_INIT: begin
            if (init_i) begin
               state_d = ST_REQ;
            end
         end

         ST_REQ: begin
            tmo_d = tmo_q + c_tmo_one;
            // Abort wins over a coinciding strobe, so that byte is dropped.
            if (w_abort) begin
               state_d = ST_ERR;
               err_d   = 1'b1;
            end else if (sd_valid_i) begin
               for (int b = 0; b < REC_BYTES; b++) begin
                  if (cnt_q == c_cnt_w'(b)) begin
                     shadow_d[8*b +: 8] = sd_data_i;
                  end
               end
               cnt_d = cnt_q + c_cnt_one;
               if (cnt_q == c_cnt_last) begin
                  state_d = ST_DRAIN;
               end
            end
         end

         ST_DRAIN: begin
            tmo_d = tmo_q + c_tmo_one;
            if (w_abort) begin
               state_d = ST_ERR;
               err_d   = 1'b1;
            end else if (sd_done_i) begin
               // Publish on the way into DONE so rec_valid lines up with it.
               state_d     = ST_DONE;
               rec_data_d  = shadow_q;
               rec_valid_d = 1'b1;
            end
         end

         ST_DONE: begin
            next_idx_d = (idx_q + 32'd1 == c_num_sec) ? 32'd0 : idx_q + 32'd1;
            state_d    = ST_IDLE;
         end

         ST_ERR: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Outputs are registered copies of what the next state implies, so
      // they track the state register with no input-to-output paths.
      read_req_d = (state_d == ST_REQ);
      busy_d     = (state_d != ST_IDLE);
   end

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge SD_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         sec_q       <= c_base_sec;
         idx_q       <= '0;
         next_idx_q  <= '0;
         cnt_q       <= '0;
         tmo_q       <= '0;
         shadow_q    <= '0;
         rec_data_q  <= '0;
         rec_valid_q <= 1'b0;
         err_q       <= 1'b0;
         read_req_q  <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         sec_q       <= sec_d;
         idx_q       <= idx_d;
         next_idx_q  <= next_idx_d;
         cnt_q       <= cnt_d;
         tmo_q       <= tmo_d;
         shadow_q    <= shadow_d;
         rec_data_q  <= rec_data_d;
         rec_valid_q <= rec_valid_d;
         err_q       <= err_d;
         read_req_q  <= read_req_d;
         busy_q      <= busy_d;
      end
   end

   assign busy      = busy_q;
   assign rec_valid = rec_valid_q;
   assign rec_data  = rec_data_q;
   assign err       = err_q;
   assign read_req  = read_req_q;
   assign sec       = sec_q;

endmodule
`default_nettype wire

// File: tb/tb_sd_record_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_sd_record_fetch
// Purpose  : Self-checking bench for sd_record_fetch. A behavioural model
//            (next index, last record, last sector, error flag) predicts the
//            outputs while randomized byte streams and handshake delays are
//            applied through a simple SD_read stand-in.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sd_record_fetch;

   localparam int BASE_SEC  = 16640;
   localparam int NUM_SEC   = 33;
   localparam int REC_BYTES = 4;
   localparam int TIMEOUT   = 64;

   logic                   SD_clk;
   logic                   rst_n;
   logic                   start;
   logic                   auto_inc;
   logic [31:0]            sec_idx;
   logic                   busy;
   logic                   rec_valid;
   logic [8*REC_BYTES-1:0] rec_data;
   logic                   err;
   logic                   init_i;
   logic                   read_req;
   logic [31:0]            sec;
   logic [7:0]             sd_data_i;
   logic                   sd_valid_i;
   logic                   sd_done_i;

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model state
   int unsigned     m_next;
   logic [31:0]     m_rec;
   logic [31:0]     m_sec;
   logic            m_err;

   sd_record_fetch #(
      .BASE_SEC  (BASE_SEC),
      .NUM_SEC   (NUM_SEC),
      .REC_BYTES (REC_BYTES),
      .TIMEOUT   (TIMEOUT)
   ) dut (
      .SD_clk     (SD_clk),
      .rst_n      (rst_n),
      .start      (start),
      .auto_inc   (auto_inc),
      .sec_idx    (sec_idx),
      .busy       (busy),
      .rec_valid  (rec_valid),
      .rec_data   (rec_data),
      .err        (err),
      .init_i     (init_i),
      .read_req   (read_req),
      .sec        (sec),
      .sd_data_i  (sd_data_i),
      .sd_valid_i (sd_valid_i),
      .sd_done_i  (sd_done_i)
   );

   initial SD_clk = 1'b0;
   always #5 SD_clk = ~SD_clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_next = 0;
      m_rec  = 32'd0;
      m_sec  = BASE_SEC;
      m_err  = 1'b0;
   endtask

   // Successful fetch. late>0 holds init_i low for that many cycles.
   task automatic good_fetch(input bit use_auto, input int unsigned idx_in,
                             input int late, input bit fixed,
                             input logic [31:0] fixed_word);
      int unsigned eff;
      logic [7:0]  bytes [REC_BYTES];
      logic [31:0] exp_word;
      int          d;
      eff      = use_auto ? m_next : idx_in;
      exp_word = 32'd0;
      for (int i = 0; i < REC_BYTES; i++) begin
         bytes[i] = fixed ? fixed_word[8*i +: 8] : 8'($urandom_range(0, 255));
         exp_word = exp_word + ({24'd0, bytes[i]} << (8 * i));
      end

      if (late > 0) init_i = 1'b0;
      start    = 1'b1;
      auto_inc = use_auto;
      sec_idx  = use_auto ? $urandom : idx_in;
      @(negedge SD_clk);
      start   = 1'b0;
      sec_idx = $urandom;
      chk("start_busy", busy, 1);
      chk("start_sec", sec, BASE_SEC + eff);
      chk("start_req", read_req, (late == 0));
      chk("start_err", err, 0);

      if (late > 0) begin
         repeat (late - 1) @(negedge SD_clk);
         chk("wait_init_req", read_req, 0);
         init_i = 1'b1;
         @(negedge SD_clk);
         chk("late_init_req", read_req, 1);
      end

      for (int i = 0; i < REC_BYTES; i++) begin
         repeat ($urandom_range(0, 2)) @(negedge SD_clk);
         sd_valid_i = 1'b1;
         sd_data_i  = bytes[i];
         @(negedge SD_clk);
         sd_valid_i = 1'b0;
         sd_data_i  = 8'($urandom);
      end
      chk("req_drop", read_req, 0);

      // Extra strobes after the record must be ignored.
      d = $urandom_range(0, 3);
      for (int k = 0; k < d; k++) begin
         sd_valid_i = 1'($urandom_range(0, 1));
         sd_data_i  = 8'($urandom);
         @(negedge SD_clk);
         chk("drain_no_valid", rec_valid, 0);
      end
      sd_valid_i = 1'b0;
      sd_done_i  = 1'b1;
      @(negedge SD_clk);
      sd_done_i = 1'b0;
      chk("rec_valid", rec_valid, 1);
      chk("rec_data", rec_data, exp_word);
      chk("done_busy", busy, 1);
      @(negedge SD_clk);
      chk("rec_valid_pulse", rec_valid, 0);
      chk("idle_busy", busy, 0);
      chk("idle_err", err, 0);

      m_rec  = exp_word;
      m_sec  = BASE_SEC + eff;
      m_err  = 1'b0;
      m_next = (eff + 1) % NUM_SEC;
   endtask

   task automatic bad_fetch(input int unsigned idx);
      start    = 1'b1;
      auto_inc = 1'b0;
      sec_idx  = idx;
      @(negedge SD_clk);
      start = 1'b0;
      chk("bad_busy", busy, 1);
      chk("bad_req", read_req, 0);
      chk("bad_err", err, 1);
      @(negedge SD_clk);
      chk("bad_idle", busy, 0);
      chk("bad_req2", read_req, 0);
      chk("bad_err_sticky", err, 1);
      chk("bad_sec_hold", sec, m_sec);
      chk("bad_rec_hold", rec_data, m_rec);
      chk("bad_no_valid", rec_valid, 0);
      m_err = 1'b1;
   endtask

   task automatic timeout_test();
      int unsigned idx;
      idx      = $urandom_range(0, NUM_SEC - 1);
      start    = 1'b1;
      auto_inc = 1'b0;
      sec_idx  = idx;
      @(negedge SD_clk);
      chk("tmo_busy", busy, 1);
      chk("tmo_req", read_req, 1);
      // Observing REQ cycle 1 here; walk to cycle 64, with a second start
      // issued while busy.
      for (int c = 1; c < TIMEOUT; c++) begin
         start   = (c == 5);
         sec_idx = (idx + 1) % NUM_SEC;
         @(negedge SD_clk);
      end
      start = 1'b0;
      chk("tmo_pre_req", read_req, 1);
      chk("tmo_pre_err", err, 0);
      chk("tmo_sec_hold", sec, BASE_SEC + idx);
      @(negedge SD_clk);
      chk("tmo_err", err, 1);
      chk("tmo_req_low", read_req, 0);
      chk("tmo_err_busy", busy, 1);
      @(negedge SD_clk);
      chk("tmo_idle", busy, 0);
      chk("tmo_rec_hold", rec_data, m_rec);
      m_sec = BASE_SEC + idx;
      m_err = 1'b1;
   endtask

   task automatic init_drop_test();
      int unsigned idx;
      idx      = $urandom_range(0, NUM_SEC - 1);
      start    = 1'b1;
      auto_inc = 1'b0;
      sec_idx  = idx;
      @(negedge SD_clk);
      start = 1'b0;
      chk("drop_req", read_req, 1);
      init_i = 1'b0;
      @(negedge SD_clk);
      chk("drop_err", err, 1);
      chk("drop_req_low", read_req, 0);
      init_i = 1'b1;
      @(negedge SD_clk);
      chk("drop_idle", busy, 0);
      m_sec = BASE_SEC + idx;
      m_err = 1'b1;
   endtask

   task automatic reset_mid_fetch();
      start    = 1'b1;
      auto_inc = 1'b0;
      sec_idx  = $urandom_range(1, NUM_SEC - 1);
      @(negedge SD_clk);
      start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         sd_valid_i = 1'b1;
         sd_data_i  = 8'($urandom);
         @(negedge SD_clk);
      end
      sd_valid_i = 1'b0;
      rst_n      = 1'b0;
      #1;
      chk("rst_req", read_req, 0);
      chk("rst_sec", sec, BASE_SEC);
      chk("rst_busy", busy, 0);
      chk("rst_valid", rec_valid, 0);
      chk("rst_data", rec_data, 0);
      chk("rst_err", err, 0);
      @(negedge SD_clk);
      rst_n = 1'b1;
      @(negedge SD_clk);
      model_reset();
   endtask

   initial begin
      rst_n      = 1'b0;
      start      = 1'b0;
      auto_inc   = 1'b0;
      sec_idx    = 32'd0;
      init_i     = 1'b1;
      sd_data_i  = 8'd0;
      sd_valid_i = 1'b0;
      sd_done_i  = 1'b0;
      model_reset();

      repeat (3) @(negedge SD_clk);
      chk("reset_req", read_req, 0);
      chk("reset_sec", sec, BASE_SEC);
      chk("reset_busy", busy, 0);
      chk("reset_valid", rec_valid, 0);
      chk("reset_data", rec_data, 0);
      chk("reset_err", err, 0);
      rst_n = 1'b1;
      @(negedge SD_clk);

      // Basic fetch
      good_fetch(1'b0, 0, 0, 1'b1, 32'h44332211);

      // Out-of-range index, then a good start clears err
      bad_fetch(NUM_SEC);
      good_fetch(1'b0, $urandom_range(0, NUM_SEC - 1), 0, 1'b0, 32'd0);

      // Top of the window wraps next index to 0
      good_fetch(1'b0, NUM_SEC - 1, 0, 1'b0, 32'd0);
      good_fetch(1'b1, 0, 0, 1'b0, 32'd0);

      // Late init
      good_fetch(1'b0, $urandom_range(0, NUM_SEC - 1), 50, 1'b0, 32'd0);

      // Random mix
      for (int n = 0; n < 10; n++) begin
         if ($urandom_range(0, 3) == 0)
            bad_fetch(NUM_SEC + $urandom_range(0, 1000));
         else
            good_fetch(1'($urandom_range(0, 1)), $urandom_range(0, NUM_SEC - 1),
                       0, 1'b0, 32'd0);
      end

      timeout_test();
      good_fetch(1'b1, 0, 0, 1'b0, 32'd0);
      init_drop_test();

      // Reset mid-fetch, then auto-increment across the wrap
      reset_mid_fetch();
      good_fetch(1'b1, 0, 0, 1'b0, 32'd0);
      for (int n = 0; n < 34; n++) begin
         good_fetch(1'b1, 0, 0, 1'b0, 32'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
